// File: rtl/pio_fifo_pair.sv
// Host-side TX/RX FIFO pair for one state machine, built on a shared
// 2*DEPTH-entry store. Unjoined, TX owns entries [0, DEPTH) and RX owns
// [DEPTH, 2*DEPTH). join_tx or join_rx hands the whole store to one direction.
// Ports:
//   clk, reset (sync, active-high), flush       - clock and clears
//   join_tx, join_rx                            - capacity mode select
//   tx_wr/tx_wdata, pull/pull_data              - TX: host writes, machine pulls
//   tx_empty/tx_full/tx_level                   - TX status
//   push/push_data, rx_rd/rx_rdata              - RX: machine pushes, host reads
//   rx_empty/rx_full/rx_level                   - RX status
//   tx_over/tx_under/rx_over/rx_under           - sticky error flags
module pio_fifo_pair #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        join_tx,
  input  logic                        join_rx,
  input  logic                        tx_wr,
  input  logic [WIDTH-1:0]            tx_wdata,
  input  logic                        pull,
  output logic [WIDTH-1:0]            pull_data,
  output logic                        tx_empty,
  output logic                        tx_full,
  output logic [$clog2(2*DEPTH):0]    tx_level,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  output logic                        rx_full,
  input  logic                        rx_rd,
  output logic [WIDTH-1:0]            rx_rdata,
  output logic                        rx_empty,
  output logic [$clog2(2*DEPTH):0]    rx_level,
  output logic                        tx_over,
  output logic                        tx_under,
  output logic                        rx_over,
  output logic                        rx_under
);

  localparam int unsigned ENTRIES = 2 * DEPTH;
  localparam int unsigned PW      = $clog2(ENTRIES);
  localparam int unsigned LW      = PW + 1;

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];

  logic [PW-1:0] tx_head_q, tx_head_d, tx_tail_q, tx_tail_d;
  logic [PW-1:0] rx_head_q, rx_head_d, rx_tail_q, rx_tail_d;
  logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic          join_tx_q, join_tx_d, join_rx_q, join_rx_d;
  logic          tx_over_q, tx_over_d, tx_under_q, tx_under_d;
  logic          rx_over_q, rx_over_d, rx_under_q, rx_under_d;

  logic [LW-1:0] tx_cap, rx_cap;
  logic [PW-1:0] rx_base;
  logic          tx_en, rx_en, clr;
  logic          tx_wr_ok, pull_ok, push_ok, rx_rd_ok;

  // Advance an index, wrapping at the active capacity.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic [LW-1:0] cap);
    return (LW'(p) + LW'(1) == cap) ? PW'(0) : p + PW'(1);
  endfunction

  // Capacity and status decode; join_tx wins when both joins are set.
  always_comb begin
    tx_cap  = join_tx ? LW'(ENTRIES) : (join_rx ? LW'(0) : LW'(DEPTH));
    rx_cap  = join_tx ? LW'(0) : (join_rx ? LW'(ENTRIES) : LW'(DEPTH));
    rx_base = join_rx ? PW'(0) : PW'(DEPTH);
    tx_en   = (tx_cap != LW'(0));
    rx_en   = (rx_cap != LW'(0));

    tx_empty = !tx_en || (tx_level_q == LW'(0));
    tx_full  = !tx_en || (tx_level_q == tx_cap);
    rx_empty = !rx_en || (rx_level_q == LW'(0));
    rx_full  = !rx_en || (rx_level_q == rx_cap);
    tx_level = tx_en ? tx_level_q : LW'(0);
    rx_level = rx_en ? rx_level_q : LW'(0);

    pull_data = mem_q[tx_head_q];
    rx_rdata  = mem_q[rx_base + rx_head_q];

    tx_wr_ok = tx_wr && !tx_full;
    pull_ok  = pull  && !tx_empty;
    push_ok  = push  && !rx_full;
    rx_rd_ok = rx_rd && !rx_empty;

    // A join change seen this cycle clears everything at the next edge.
    clr = reset || flush || (join_tx != join_tx_q) || (join_rx != join_rx_q);
  end

  // Next-state for pointers, levels, sticky flags and storage.
  always_comb begin
    mem_d      = mem_q;
    tx_head_d  = tx_head_q;
    tx_tail_d  = tx_tail_q;
    rx_head_d  = rx_head_q;
    rx_tail_d  = rx_tail_q;
    tx_level_d = tx_level_q;
    rx_level_d = rx_level_q;
    join_tx_d  = join_tx;
    join_rx_d  = join_rx;
    tx_over_d  = tx_over_q  || (tx_wr && tx_full);
    tx_under_d = tx_under_q || (pull  && tx_empty);
    rx_over_d  = rx_over_q  || (push  && rx_full);
    rx_under_d = rx_under_q || (rx_rd && rx_empty);

    if (clr) begin
      tx_head_d  = '0;
      tx_tail_d  = '0;
      rx_head_d  = '0;
      rx_tail_d  = '0;
      tx_level_d = '0;
      rx_level_d = '0;
      tx_over_d  = 1'b0;
      tx_under_d = 1'b0;
      rx_over_d  = 1'b0;
      rx_under_d = 1'b0;
    end else begin
      if (tx_wr_ok) begin
        mem_d[tx_tail_q] = tx_wdata;
        tx_tail_d        = ptr_inc(tx_tail_q, tx_cap);
      end
      if (pull_ok) tx_head_d = ptr_inc(tx_head_q, tx_cap);
      if (tx_wr_ok && !pull_ok)      tx_level_d = tx_level_q + LW'(1);
      else if (!tx_wr_ok && pull_ok) tx_level_d = tx_level_q - LW'(1);

      if (push_ok) begin
        mem_d[rx_base + rx_tail_q] = push_data;
        rx_tail_d                  = ptr_inc(rx_tail_q, rx_cap);
      end
      if (rx_rd_ok) rx_head_d = ptr_inc(rx_head_q, rx_cap);
      if (push_ok && !rx_rd_ok)      rx_level_d = rx_level_q + LW'(1);
      else if (!push_ok && rx_rd_ok) rx_level_d = rx_level_q - LW'(1);
    end
  end

  // Control state; reset folds into clr so it acts synchronously.
  always_ff @(posedge clk) begin
    tx_head_q  <= tx_head_d;
    tx_tail_q  <= tx_tail_d;
    rx_head_q  <= rx_head_d;
    rx_tail_q  <= rx_tail_d;
    tx_level_q <= tx_level_d;
    rx_level_q <= rx_level_d;
    join_tx_q  <= join_tx_d;
    join_rx_q  <= join_rx_d;
    tx_over_q  <= tx_over_d;
    tx_under_q <= tx_under_d;
    rx_over_q  <= rx_over_d;
    rx_under_q <= rx_under_d;
  end

  // Storage is never cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx_over  = tx_over_q;
  assign tx_under = tx_under_q;
  assign rx_over  = rx_over_q;
  assign rx_under = rx_under_q;

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Directed test of pio_fifo_pair (WIDTH=32, DEPTH=4).
module tb_pio_fifo_pair;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(2*DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, flush, join_tx, join_rx;
  logic             tx_wr, pull, push, rx_rd;
  logic [WIDTH-1:0] tx_wdata, push_data, pull_data, rx_rdata;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic [LW-1:0]    tx_level, rx_level;
  logic             tx_over, tx_under, rx_over, rx_under;

  int n_checks = 0;
  int n_pass   = 0;

  pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .join_tx(join_tx), .join_rx(join_rx),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata),
    .pull(pull), .pull_data(pull_data),
    .tx_empty(tx_empty), .tx_full(tx_full), .tx_level(tx_level),
    .push(push), .push_data(push_data),
    .rx_full(rx_full), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
    .rx_empty(rx_empty), .rx_level(rx_level),
    .tx_over(tx_over), .tx_under(tx_under),
    .rx_over(rx_over), .rx_under(rx_under)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; join_tx = 1'b0; join_rx = 1'b0;
    tx_wr = 1'b0; pull = 1'b0; push = 1'b0; rx_rd = 1'b0;
    tx_wdata = '0; push_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full",  32'(tx_full),  32'd0);
    check("rst_rx_full",  32'(rx_full),  32'd0);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_flags", 32'({tx_over, tx_under, rx_over, rx_under}), 32'd0);

    // Fill TX, overflow, drain in order
    for (int i = 0; i < 4; i++) begin
      tx_wr = 1'b1; tx_wdata = 32'hA0 + 32'(i);
      tick();
    end
    tx_wr = 1'b0;
    check("fill_tx_full",  32'(tx_full),  32'd1);
    check("fill_tx_level", 32'(tx_level), 32'd4);
    check("fill_tx_over0", 32'(tx_over),  32'd0);
    tx_wr = 1'b1; tx_wdata = 32'hA4;
    tick();
    tx_wr = 1'b0;
    check("ovf_tx_over",  32'(tx_over),  32'd1);
    check("ovf_tx_level", 32'(tx_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", pull_data, 32'hA0 + 32'(i));
      pull = 1'b1;
      tick();
    end
    pull = 1'b0;
    check("drain_tx_empty", 32'(tx_empty), 32'd1);
    check("drain_tx_level", 32'(tx_level), 32'd0);

    // Simultaneous write+pull at level 2, wrapping the ring
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_tx_over", 32'(tx_over), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tx_wr = 1'b1; tx_wdata = 32'hB0 + 32'(i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      check("rw_head", pull_data, 32'hB0 + 32'(i));
      tx_wr = 1'b1; pull = 1'b1; tx_wdata = 32'hB2 + 32'(i);
      tick();
      check("rw_level", 32'(tx_level), 32'd2);
    end
    tx_wr = 1'b0;
    check("rw_tail0", pull_data, 32'hBA);
    tick();
    check("rw_tail1", pull_data, 32'hBB);
    tick();
    pull = 1'b0;
    check("rw_empty", 32'(tx_empty), 32'd1);

    // join_rx: 8-deep RX, TX disabled
    join_rx = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      check("jrx_not_full", 32'(rx_full), 32'd0);
      push = 1'b1; push_data = 32'(i);
      tick();
    end
    push = 1'b0;
    check("jrx_rx_full",  32'(rx_full),  32'd1);
    check("jrx_rx_level", 32'(rx_level), 32'd8);
    check("jrx_tx_full",  32'(tx_full),  32'd1);
    check("jrx_tx_empty", 32'(tx_empty), 32'd1);
    check("jrx_tx_level", 32'(tx_level), 32'd0);
    tx_wr = 1'b1; tx_wdata = 32'hEE; tick(); tx_wr = 1'b0;
    check("jrx_tx_over", 32'(tx_over), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("jrx_rdata", rx_rdata, 32'(i));
      rx_rd = 1'b1;
      tick();
    end
    rx_rd = 1'b0;
    check("jrx_rx_empty", 32'(rx_empty), 32'd1);
    check("jrx_rx_under", 32'(rx_under), 32'd0);

    // Leaving join_rx flushes; join_tx toggle with TX at level 3 flushes
    join_rx = 1'b0; tick();
    check("unjoin_tx_over", 32'(tx_over), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1'b1; tx_wdata = 32'hC0 + 32'(i);
      tick();
    end
    tx_wr = 1'b0;
    push = 1'b1; push_data = 32'h55; tick(); push = 1'b0;
    check("jtx_pre_level", 32'(tx_level), 32'd3);
    check("jtx_pre_rx",    32'(rx_level), 32'd1);
    join_tx = 1'b1; tick();
    check("jtx_tx_level", 32'(tx_level), 32'd0);
    check("jtx_tx_empty", 32'(tx_empty), 32'd1);
    check("jtx_rx_level", 32'(rx_level), 32'd0);
    join_tx = 1'b0; tick();

    // Underflow on empty TX, cleared by flush
    pull = 1'b1; tick(); pull = 1'b0;
    check("und_tx_under", 32'(tx_under), 32'd1);
    check("und_tx_level", 32'(tx_level), 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    check("und_flushed", 32'(tx_under), 32'd0);

    // RX full with push+rx_rd together: push dropped, read accepted
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = 32'h10 + 32'(i);
      tick();
    end
    check("rxf_full", 32'(rx_full), 32'd1);
    push = 1'b1; push_data = 32'h99; rx_rd = 1'b1;
    tick();
    push = 1'b0; rx_rd = 1'b0;
    check("rxf_over",  32'(rx_over),  32'd1);
    check("rxf_level", 32'(rx_level), 32'd3);
    check("rxf_head",  rx_rdata,      32'h11);
    check("rxf_tx_ok", 32'(tx_empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
